seg_scan_controller: RTL and testbench

Time-multiplexed scan controller that shares one BCD-to-7-segment decoder among `DIGITS` common-anode/cathode digit positions of the alarm panel display. It latches a packed BCD word from the game/timer logic and double-buffers it so updates land only at frame boundaries. It walks the digits round-robin, presenting each digit's nibble to the decoder and asserting that digit's select line. A guard interval blanks each digit slot at its start to prevent ghosting.

---
 rtl/seg_scan_controller.sv | 149 ++++++++++++++
 tb/tb_seg_scan_controller.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_controller.sv
// Round-robin 7-segment digit scanner with frame-synchronous double buffering and guard blanking.
// Optional leading-zero blanking is compiled in when SEG_SCAN_LZB_EN is defined.
module seg_scan_controller #(
    parameter int unsigned DIGITS       = 8,
    parameter int unsigned SLOT_CYCLES  = 1000,
    parameter int unsigned GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    output logic [3:0]            bcd_out,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_start
);

    localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CntW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    localparam logic [IdxW-1:0] LastIdx   = IdxW'(DIGITS - 1);
    localparam logic [CntW-1:0] LastSlot  = CntW'(SLOT_CYCLES - 1);
    localparam logic [CntW-1:0] LastGuard = CntW'(GUARD_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StGuard, StDrive} state_e;

    state_e                state_q, state_d;
    logic [IdxW-1:0]       idx_q, idx_d;
    logic [CntW-1:0]       slot_cnt_q, slot_cnt_d;
    logic [4*DIGITS-1:0]   pending_q, pending_d;
    logic                  pending_valid_q, pending_valid_d;
    logic [4*DIGITS-1:0]   shown_q, shown_d;
    logic [3:0]            bcd_q, bcd_d;
    logic [DIGITS-1:0]     sel_q, sel_d;
    logic                  fs_q, fs_d;
    logic                  commit;
`ifdef SEG_SCAN_LZB_EN
    logic                  upper_zero;
`endif

    always_comb begin
        state_d         = state_q;
        idx_d           = idx_q;
        slot_cnt_d      = slot_cnt_q;
        pending_d       = pending_q;
        pending_valid_d = pending_valid_q;
        shown_d         = shown_q;
        commit          = 1'b0;

        if (!enable) begin
            state_d    = StIdle;
            idx_d      = '0;
            slot_cnt_d = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d    = StGuard;
                    idx_d      = '0;
                    slot_cnt_d = '0;
                    commit     = 1'b1;
                end
                StGuard: begin
                    slot_cnt_d = slot_cnt_q + 1'b1;
                    if (slot_cnt_q == LastGuard) begin
                        state_d = StDrive;
                    end
                end
                StDrive: begin
                    if (slot_cnt_q == LastSlot) begin
                        state_d    = StGuard;
                        slot_cnt_d = '0;
                        if (idx_q == LastIdx) begin
                            idx_d  = '0;
                            commit = 1'b1;
                        end else begin
                            idx_d = idx_q + 1'b1;
                        end
                    end else begin
                        slot_cnt_d = slot_cnt_q + 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        // Commit reads the old pending word; a coincident load refills it afterwards.
        if (commit && pending_valid_q) begin
            shown_d         = pending_q;
            pending_valid_d = 1'b0;
        end
        if (load) begin
            pending_d       = data_in;
            pending_valid_d = 1'b1;
        end
    end

    // Outputs are derived from next state so they register alongside it.
    always_comb begin
        bcd_d = 4'hF;
        sel_d = '0;
        fs_d  = (state_d == StGuard) && (idx_d == '0) && (slot_cnt_d == '0);
`ifdef SEG_SCAN_LZB_EN
        upper_zero = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
`ifdef SEG_SCAN_LZB_EN
            upper_zero = upper_zero && (shown_d[4*i +: 4] == 4'h0);
`endif
            if ((state_d == StDrive) && (idx_d == IdxW'(i))) begin
                sel_d[i] = 1'b1;
                bcd_d    = shown_d[4*i +: 4];
`ifdef SEG_SCAN_LZB_EN
                if ((i != 0) && upper_zero) begin
                    bcd_d = 4'hF;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= StIdle;
            idx_q           <= '0;
            slot_cnt_q      <= '0;
            pending_q       <= '0;
            pending_valid_q <= 1'b0;
            shown_q         <= '0;
            bcd_q           <= 4'hF;
            sel_q           <= '0;
            fs_q            <= 1'b0;
        end else begin
            state_q         <= state_d;
            idx_q           <= idx_d;
            slot_cnt_q      <= slot_cnt_d;
            pending_q       <= pending_d;
            pending_valid_q <= pending_valid_d;
            shown_q         <= shown_d;
            bcd_q           <= bcd_d;
            sel_q           <= sel_d;
            fs_q            <= fs_d;
        end
    end

    assign bcd_out     = bcd_q;
    assign digit_sel   = sel_q;
    assign frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: per-cycle scoreboard from a frame-position model plus a segment table.
// Honours SEG_SCAN_LZB_EN to match the build under test.
module tb_seg_scan_controller;

    localparam int D  = 4;
    localparam int S  = 8;
    localparam int G  = 2;
    localparam int FR = D * S;
`ifdef SEG_SCAN_LZB_EN
    localparam logic [3:0] LzBlank = 4'hF;
`else
    localparam logic [3:0] LzBlank = 4'h0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        enable;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  bcd_out;
    logic [3:0]  digit_sel;
    logic        frame_start;

    seg_scan_controller #(
        .DIGITS      (D),
        .SLOT_CYCLES (S),
        .GUARD_CYCLES(G)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .load       (load),
        .data_in    (data_in),
        .bcd_out    (bcd_out),
        .digit_sel  (digit_sel),
        .frame_start(frame_start)
    );

    typedef struct packed {
        logic [3:0] sel;
        logic [3:0] bcd;
        logic       fs;
    } exp_t;

    typedef struct {
        logic        en;
        logic        ld;
        logic [15:0] data;
        int          n;
        logic [3:0]  sel;
        logic [3:0]  bcd;
        logic        fs;
    } vec_t;

    exp_t sb_q[$];
    vec_t vt[24];
    int   checks = 0;
    int   errors = 0;

    // Model: position within the frame since scanning started.
    bit          m_run;
    int          m_pos;
    logic [15:0] m_shown;
    logic [15:0] m_pend;
    bit          m_pv;

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_shown = '0; m_pend = '0; m_pv = 0;
    endtask

    task automatic model_edge(input logic en, input logic ld, input logic [15:0] d);
        if (!en) begin
            m_run = 0; m_pos = 0;
        end else if (!m_run) begin
            m_run = 1; m_pos = 0;
        end else begin
            m_pos = (m_pos + 1) % FR;
        end
        if (en && m_pos == 0 && m_pv) begin
            m_shown = m_pend; m_pv = 0;
        end
        if (ld) begin
            m_pend = d; m_pv = 1;
        end
    endtask

    function automatic exp_t model_out();
        exp_t e;
        int   dig;
        int   off;
        e.sel = '0; e.bcd = 4'hF; e.fs = 1'b0;
        if (m_run) begin
            dig = m_pos / S;
            off = m_pos % S;
            if (off < G) begin
                e.fs = (off == 0) && (dig == 0);
            end else begin
                e.sel = 4'(1 << dig);
                e.bcd = m_shown[dig*4 +: 4];
`ifdef SEG_SCAN_LZB_EN
                begin : lzb
                    bit z;
                    z = 1;
                    for (int k = dig; k < D; k++) if (m_shown[k*4 +: 4] != 4'h0) z = 0;
                    if (dig > 0 && z) e.bcd = 4'hF;
                end
`endif
            end
        end
        return e;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic step();
        exp_t e;
        model_edge(enable, load, data_in);
        sb_q.push_back(model_out());
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("sb_digit_sel", 8'(digit_sel), 8'(e.sel));
        check("sb_bcd_out", 8'(bcd_out), 8'(e.bcd));
        check("sb_frame_start", 8'(frame_start), 8'(e.fs));
    endtask

    initial begin
        vt[0]  = '{1'b1, 1'b0, 16'h0000,  1, 4'b0000, 4'hF,    1'b1};
        vt[1]  = '{1'b1, 1'b0, 16'h0000,  2, 4'b0001, 4'h0,    1'b0};
        vt[2]  = '{1'b1, 1'b0, 16'h0000, 16, 4'b0100, 4'h0,    1'b0};
        vt[3]  = '{1'b1, 1'b1, 16'h1234,  1, 4'b0100, 4'h0,    1'b0};
        vt[4]  = '{1'b1, 1'b0, 16'h0000, 12, 4'b1000, 4'h0,    1'b0};
        vt[5]  = '{1'b1, 1'b0, 16'h0000,  1, 4'b0000, 4'hF,    1'b1};
        vt[6]  = '{1'b1, 1'b0, 16'h0000,  2, 4'b0001, 4'h4,    1'b0};
        vt[7]  = '{1'b1, 1'b0, 16'h0000,  8, 4'b0010, 4'h3,    1'b0};
        vt[8]  = '{1'b1, 1'b1, 16'h1111,  1, 4'b0010, 4'h3,    1'b0};
        vt[9]  = '{1'b1, 1'b0, 16'h0000, 20, 4'b1000, 4'h1,    1'b0};
        vt[10] = '{1'b1, 1'b1, 16'h5678,  1, 4'b0000, 4'hF,    1'b1};
        vt[11] = '{1'b1, 1'b0, 16'h0000, 26, 4'b1000, 4'h1,    1'b0};
        vt[12] = '{1'b1, 1'b0, 16'h0000,  6, 4'b0000, 4'hF,    1'b1};
        vt[13] = '{1'b1, 1'b0, 16'h0000, 10, 4'b0010, 4'h7,    1'b0};
        vt[14] = '{1'b0, 1'b0, 16'h0000,  1, 4'b0000, 4'hF,    1'b0};
        vt[15] = '{1'b0, 1'b0, 16'h0000,  3, 4'b0000, 4'hF,    1'b0};
        vt[16] = '{1'b1, 1'b0, 16'h0000,  1, 4'b0000, 4'hF,    1'b1};
        vt[17] = '{1'b1, 1'b0, 16'h0000,  2, 4'b0001, 4'h8,    1'b0};
        vt[18] = '{1'b1, 1'b1, 16'h0070,  1, 4'b0001, 4'h8,    1'b0};
        vt[19] = '{1'b1, 1'b0, 16'h0000, 29, 4'b0000, 4'hF,    1'b1};
        vt[20] = '{1'b1, 1'b0, 16'h0000,  2, 4'b0001, 4'h0,    1'b0};
        vt[21] = '{1'b1, 1'b0, 16'h0000,  8, 4'b0010, 4'h7,    1'b0};
        vt[22] = '{1'b1, 1'b0, 16'h0000,  8, 4'b0100, LzBlank, 1'b0};
        vt[23] = '{1'b1, 1'b0, 16'h0000,  8, 4'b1000, LzBlank, 1'b0};

        rst_n = 1'b0; enable = 1'b0; load = 1'b0; data_in = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_digit_sel", 8'(digit_sel), 8'h00);
        check("rst_bcd_out", 8'(bcd_out), 8'h0F);
        check("rst_frame_start", 8'(frame_start), 8'h00);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 24; v++) begin
            enable  = vt[v].en;
            data_in = vt[v].data;
            for (int c = 0; c < vt[v].n; c++) begin
                load = vt[v].ld && (c == 0);
                step();
            end
            load = 1'b0;
            check($sformatf("tbl%0d_digit_sel", v), 8'(digit_sel), 8'(vt[v].sel));
            check($sformatf("tbl%0d_bcd_out", v), 8'(bcd_out), 8'(vt[v].bcd));
            check($sformatf("tbl%0d_frame_start", v), 8'(frame_start), 8'(vt[v].fs));
        end

        // Asynchronous reset mid-slot, well away from any clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_digit_sel", 8'(digit_sel), 8'h00);
        check("arst_bcd_out", 8'(bcd_out), 8'h0F);
        check("arst_frame_start", 8'(frame_start), 8'h00);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
